// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode constants for the decode stage.
//   - opcode values for the nine base instruction classes
//   - ALU_Control operation codes
//   - op_A_sel operand encodings
//   - dec_bundle_t, the decoded control/field bundle carried by the stage
package riscv_pkg;

  // Base opcode classes (inst[6:0])
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LUI    = 7'b0110111;

  // ALU_Control codes; the low three bits of the plain ops equal funct3
  localparam logic [5:0] ALU_ADD    = 6'b000000;
  localparam logic [5:0] ALU_SLL    = 6'b000001;
  localparam logic [5:0] ALU_SLT    = 6'b000010;
  localparam logic [5:0] ALU_SLTU   = 6'b000011;
  localparam logic [5:0] ALU_XOR    = 6'b000100;
  localparam logic [5:0] ALU_SRL    = 6'b000101;
  localparam logic [5:0] ALU_OR     = 6'b000110;
  localparam logic [5:0] ALU_AND    = 6'b000111;
  localparam logic [5:0] ALU_SUB    = 6'b001000;
  localparam logic [5:0] ALU_SRA    = 6'b001101;
  localparam logic [2:0] ALU_BR_HI  = 3'b010;   // branches: {010, funct3}
  localparam logic [5:0] ALU_JAL    = 6'b011111;
  localparam logic [5:0] ALU_JALR   = 6'b111111;

  // op_A_sel encodings
  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic        mem_wen;
    logic        wb_sel;
    logic        branch_op;
    logic        next_pc_sel;
    logic        op_b_sel;
    logic [1:0]  op_a_sel;
    logic [31:0] imm;
    logic [5:0]  alu;
    logic        illegal;
  } dec_bundle_t;

endpackage

// File: rtl/decode_comb.sv
// decode_comb: pure combinational RV32I field / immediate / control decoder.
// Ports:
//   instruction  in   32  raw instruction word
//   bundle       out      decoded fields and controls (dec_bundle_t)
//   rs1_used     out  1   instruction reads rs1
//   rs2_used     out  1   instruction reads rs2
import riscv_pkg::*;

module decode_comb (
  input  logic [31:0] instruction,
  output dec_bundle_t bundle,
  output logic        rs1_used,
  output logic        rs2_used
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_shamt;

  assign opcode    = instruction[6:0];
  assign funct3    = instruction[14:12];
  assign imm_i     = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s     = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b     = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u     = {instruction[31:12], 12'd0};
  assign imm_j     = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
  // Immediate shifts carry only the 5-bit shift amount
  assign imm_shamt = {27'd0, instruction[24:20]};

  // Class decode: per-opcode controls, immediate format and source usage
  always_comb begin
    bundle     = '0;
    bundle.rs1 = instruction[19:15];
    bundle.rs2 = instruction[24:20];
    bundle.rd  = instruction[11:7];
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    case (opcode)
      R_TYPE: begin
        bundle.wen = 1'b1;
        bundle.alu = {3'b000, funct3};
        // funct7[5] turns add into sub and srl into sra
        if (instruction[30] && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          bundle.alu[3] = 1'b1;
        end else begin
          bundle.alu[3] = 1'b0;
        end
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      I_TYPE: begin
        bundle.wen      = 1'b1;
        bundle.op_b_sel = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          bundle.imm = imm_shamt;
        end else begin
          bundle.imm = imm_i;
        end
        // Only srai uses inst[30]; addi never becomes sub
        if (funct3 == 3'b101 && instruction[30]) begin
          bundle.alu = ALU_SRA;
        end else begin
          bundle.alu = {3'b000, funct3};
        end
        rs1_used = 1'b1;
      end
      LOAD: begin
        bundle.wen      = 1'b1;
        bundle.wb_sel   = 1'b1;
        bundle.op_b_sel = 1'b1;
        bundle.imm      = imm_i;
        bundle.alu      = ALU_ADD;
        rs1_used        = 1'b1;
      end
      STORE: begin
        bundle.mem_wen  = 1'b1;
        bundle.op_b_sel = 1'b1;
        bundle.imm      = imm_s;
        bundle.alu      = ALU_ADD;
        rs1_used        = 1'b1;
        rs2_used        = 1'b1;
      end
      BRANCH: begin
        bundle.branch_op = 1'b1;
        bundle.imm       = imm_b;
        bundle.alu       = {ALU_BR_HI, funct3};
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
      end
      JAL: begin
        bundle.wen         = 1'b1;
        bundle.next_pc_sel = 1'b1;
        bundle.imm         = imm_j;
        bundle.alu         = ALU_JAL;
      end
      JALR: begin
        bundle.wen         = 1'b1;
        bundle.next_pc_sel = 1'b1;
        bundle.op_b_sel    = 1'b1;
        bundle.imm         = imm_i;
        bundle.alu         = ALU_JALR;
        rs1_used           = 1'b1;
      end
      AUIPC: begin
        bundle.wen      = 1'b1;
        bundle.op_a_sel = OPA_PC;
        bundle.op_b_sel = 1'b1;
        bundle.imm      = imm_u;
        bundle.alu      = ALU_ADD;
      end
      LUI: begin
        bundle.wen      = 1'b1;
        bundle.op_a_sel = OPA_ZERO;
        bundle.op_b_sel = 1'b1;
        bundle.imm      = imm_u;
        bundle.alu      = ALU_ADD;
      end
      default: begin
        // Unknown opcode still flows so downstream can trap; nothing is written
        bundle.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked RV32I decode stage.
// Accepts one instruction per cycle from fetch, decodes it via decode_comb,
// tracks pending register writes of SB_DEPTH downstream stages, stalls on
// read-after-write hazards and squashes its output on flush.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       fetch handshake; PC, instruction = incoming word
//   flush                   redirect from execute, squashes the output register
//   out_valid/out_ready     downstream handshake; out_PC = PC of the bundle
//   read_sel1/2, write_sel  rs1, rs2, rd
//   wEn .. op_A_sel         control signals; imm32, ALU_Control, illegal
import riscv_pkg::*;

module decode_stage #(
  parameter int ADDRESS_BITS = 16,
  parameter int SB_DEPTH     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [31:0]             instruction,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_BITS-1:0] out_PC,
  output logic [4:0]              read_sel1,
  output logic [4:0]              read_sel2,
  output logic [4:0]              write_sel,
  output logic                    wEn,
  output logic                    mem_wEn,
  output logic                    wb_sel,
  output logic                    branch_op,
  output logic                    next_PC_select,
  output logic                    op_B_sel,
  output logic [1:0]              op_A_sel,
  output logic [31:0]             imm32,
  output logic [5:0]              ALU_Control,
  output logic                    illegal
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  dec_bundle_t                     dec;
  logic                            dec_rs1_used;
  logic                            dec_rs2_used;
  logic                            advance;
  logic                            hazard;
  logic                            src1_hit;
  logic                            src2_hit;

  logic                            out_valid_q, out_valid_d;
  dec_bundle_t                     out_bundle_q, out_bundle_d;
  logic [ADDRESS_BITS-1:0]         out_pc_q, out_pc_d;
  logic [SB_DEPTH-1:0]             sb_valid_q, sb_valid_d;
  logic [SB_DEPTH-1:0][4:0]        sb_rd_q, sb_rd_d;
  logic [0:0]                      state_q, state_d;

  decode_comb u_decode_comb (
    .instruction (instruction),
    .bundle      (dec),
    .rs1_used    (dec_rs1_used),
    .rs2_used    (dec_rs2_used)
  );

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance && !hazard && !flush;

  // Hazard: a used nonzero source matches the output bundle's rd or a live slot
  always_comb begin
    src1_hit = 1'b0;
    src2_hit = 1'b0;
    if (out_valid_q && out_bundle_q.wen) begin
      src1_hit = (out_bundle_q.rd == dec.rs1);
      src2_hit = (out_bundle_q.rd == dec.rs2);
    end else begin
      src1_hit = 1'b0;
      src2_hit = 1'b0;
    end
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_valid_q[i]) begin
        src1_hit = src1_hit || (sb_rd_q[i] == dec.rs1);
        src2_hit = src2_hit || (sb_rd_q[i] == dec.rs2);
      end else begin
        src1_hit = src1_hit;
        src2_hit = src2_hit;
      end
    end
    hazard = (dec_rs1_used && (dec.rs1 != 5'd0) && src1_hit) ||
             (dec_rs2_used && (dec.rs2 != 5'd0) && src2_hit);
  end

  // Scoreboard: on advance the departing bundle's write enters slot 0, oldest drops
  always_comb begin
    sb_valid_d = sb_valid_q;
    sb_rd_d    = sb_rd_q;
    if (advance) begin
      sb_valid_d[0] = out_valid_q && out_bundle_q.wen && (out_bundle_q.rd != 5'd0);
      sb_rd_d[0]    = out_bundle_q.rd;
      for (int i = 1; i < SB_DEPTH; i++) begin
        sb_valid_d[i] = sb_valid_q[i-1];
        sb_rd_d[i]    = sb_rd_q[i-1];
      end
    end else begin
      sb_valid_d = sb_valid_q;
      sb_rd_d    = sb_rd_q;
    end
  end

  // Output register: flush squashes even a held bundle; a stalled advance inserts a bubble
  always_comb begin
    out_valid_d  = out_valid_q;
    out_bundle_d = out_bundle_q;
    out_pc_d     = out_pc_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (advance) begin
      if (in_valid && in_ready) begin
        out_valid_d  = 1'b1;
        out_bundle_d = dec;
        out_pc_d     = PC;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // RUN/STALL tracking: flush forces RUN, a presented hazard enters STALL
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_RUN;
    end else if (hazard && in_valid) begin
      state_d = ST_STALL;
    end else if (hazard && (state_q == ST_STALL)) begin
      state_d = ST_STALL;
    end else begin
      state_d = ST_RUN;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_bundle_q <= '0;
      out_pc_q     <= '0;
      sb_valid_q   <= '0;
      sb_rd_q      <= '0;
      state_q      <= ST_RUN;
    end else begin
      out_valid_q  <= out_valid_d;
      out_bundle_q <= out_bundle_d;
      out_pc_q     <= out_pc_d;
      sb_valid_q   <= sb_valid_d;
      sb_rd_q      <= sb_rd_d;
      state_q      <= state_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_PC         = out_pc_q;
  assign read_sel1      = out_bundle_q.rs1;
  assign read_sel2      = out_bundle_q.rs2;
  assign write_sel      = out_bundle_q.rd;
  assign wEn            = out_bundle_q.wen;
  assign mem_wEn        = out_bundle_q.mem_wen;
  assign wb_sel         = out_bundle_q.wb_sel;
  assign branch_op      = out_bundle_q.branch_op;
  assign next_PC_select = out_bundle_q.next_pc_sel;
  assign op_B_sel       = out_bundle_q.op_b_sel;
  assign op_A_sel       = out_bundle_q.op_a_sel;
  assign imm32          = out_bundle_q.imm;
  assign ALU_Control    = out_bundle_q.alu;
  assign illegal        = out_bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed test-plan cases plus randomized traffic against a
// behavioural model (decode from bit-field rules, scoreboard as a queue of rd).
module tb_decode_stage;

  localparam int AW  = 16;
  localparam int SBD = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] PC;
  logic [31:0]   instruction;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_PC;
  logic [4:0]    read_sel1, read_sel2, write_sel;
  logic          wEn, mem_wEn, wb_sel, branch_op, next_PC_select, op_B_sel;
  logic [1:0]    op_A_sel;
  logic [31:0]   imm32;
  logic [5:0]    ALU_Control;
  logic          illegal;

  always #5 clock = ~clock;

  decode_stage #(.ADDRESS_BITS(AW), .SB_DEPTH(SBD)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .PC(PC), .instruction(instruction), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_PC(out_PC), .read_sel1(read_sel1),
    .read_sel2(read_sel2), .write_sel(write_sel), .wEn(wEn), .mem_wEn(mem_wEn),
    .wb_sel(wb_sel), .branch_op(branch_op), .next_PC_select(next_PC_select),
    .op_B_sel(op_B_sel), .op_A_sel(op_A_sel), .imm32(imm32),
    .ALU_Control(ALU_Control), .illegal(illegal)
  );

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic        wen, mem_wen, wb, br, npc, opb;
    logic [1:0]  opa;
    logic [31:0] imm;
    logic [5:0]  alu;
    logic        ill, use1, use2;
  } exp_t;

  int      n_vec = 0;
  int      n_bad = 0;
  logic    m_valid = 1'b0;
  logic [AW-1:0] m_pc = '0;
  exp_t    m_b = '0;
  int      sbq[$];          // sbq[0] youngest; 0 = no pending write
  logic    seen_ready;
  int      stalls;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int sh);
    logic signed [31:0] t;
    t = v;
    return t >>> sh;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] i);
    exp_t e;
    logic [2:0] f3;
    f3 = i[14:12];
    e = '0;
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    case (i[6:0])
      7'h33: begin
        e.wen = 1'b1; e.use1 = 1'b1; e.use2 = 1'b1;
        e.alu = 6'(f3) + ((i[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 6'd8 : 6'd0);
      end
      7'h13: begin
        e.wen = 1'b1; e.opb = 1'b1; e.use1 = 1'b1;
        e.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(i[24:20]) : sx({i[31:20], 20'd0}, 20);
        e.alu = 6'(f3) + ((f3 == 3'd5 && i[30]) ? 6'd8 : 6'd0);
      end
      7'h03: begin
        e.wen = 1'b1; e.wb = 1'b1; e.opb = 1'b1; e.use1 = 1'b1;
        e.imm = sx({i[31:20], 20'd0}, 20);
      end
      7'h23: begin
        e.mem_wen = 1'b1; e.opb = 1'b1; e.use1 = 1'b1; e.use2 = 1'b1;
        e.imm = sx({i[31:25], i[11:7], 20'd0}, 20);
      end
      7'h63: begin
        e.br = 1'b1; e.use1 = 1'b1; e.use2 = 1'b1;
        e.imm = sx({i[31], i[7], i[30:25], i[11:8], 1'b0, 19'd0}, 19);
        e.alu = 6'd16 + 6'(f3);
      end
      7'h6f: begin
        e.wen = 1'b1; e.npc = 1'b1; e.alu = 6'd31;
        e.imm = sx({i[31], i[19:12], i[20], i[30:21], 1'b0, 11'd0}, 11);
      end
      7'h67: begin
        e.wen = 1'b1; e.npc = 1'b1; e.opb = 1'b1; e.use1 = 1'b1; e.alu = 6'd63;
        e.imm = sx({i[31:20], 20'd0}, 20);
      end
      7'h17: begin
        e.wen = 1'b1; e.opa = 2'd1; e.opb = 1'b1; e.imm = {i[31:12], 12'd0};
      end
      7'h37: begin
        e.wen = 1'b1; e.opa = 2'd2; e.opb = 1'b1; e.imm = {i[31:12], 12'd0};
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic pending(input logic [4:0] r);
    logic p;
    p = m_valid && m_b.wen && (m_b.rd == r);
    foreach (sbq[k]) if (sbq[k] == int'(r)) p = 1'b1;
    return p && (r != 5'd0);
  endfunction

  // One clock of stimulus with model prediction and comparison
  task automatic cycle(input logic iv, input logic [31:0] inst, input logic fl,
                       input logic ordy, input logic rst);
    exp_t d;
    logic adv, haz, rdy;
    @(negedge clock);
    in_valid = iv; instruction = inst; PC = AW'($urandom);
    flush = fl; out_ready = ordy; reset = rst;
    #1;
    d   = ref_decode(inst);
    adv = !m_valid || ordy;
    haz = (d.use1 && pending(d.rs1)) || (d.use2 && pending(d.rs2));
    rdy = adv && !haz && !fl;
    seen_ready = in_ready;
    if (!rst) check_eq("in_ready", 64'(in_ready), 64'(rdy));
    @(posedge clock);
    if (rst) begin
      m_valid = 1'b0; m_pc = '0; m_b = '0;
      sbq.delete();
      for (int k = 0; k < SBD; k++) sbq.push_back(0);
    end else begin
      if (adv) begin
        sbq.push_front((m_valid && m_b.wen) ? int'(m_b.rd) : 0);
        void'(sbq.pop_back());
      end
      if (fl) m_valid = 1'b0;
      else if (adv) begin
        if (iv && rdy) begin
          m_valid = 1'b1; m_b = d; m_pc = PC;
        end else m_valid = 1'b0;
      end
    end
    #1;
    check_eq("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check_eq("out_PC", 64'(out_PC), 64'(m_pc));
      check_eq("sels", 64'({read_sel1, read_sel2, write_sel}), 64'({m_b.rs1, m_b.rs2, m_b.rd}));
      check_eq("ctrl", 64'({wEn, mem_wEn, wb_sel, branch_op, next_PC_select, op_B_sel, op_A_sel, illegal}),
               64'({m_b.wen, m_b.mem_wen, m_b.wb, m_b.br, m_b.npc, m_b.opb, m_b.opa, m_b.ill}));
      check_eq("imm32", 64'(imm32), 64'(m_b.imm));
      check_eq("ALU_Control", 64'(ALU_Control), 64'(m_b.alu));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid_pc"}, 64'({out_valid, out_PC}), 64'd0);
    check_eq({tag, "_fields"}, {read_sel1, read_sel2, write_sel, wEn, mem_wEn, wb_sel, branch_op,
             next_PC_select, op_B_sel, op_A_sel, illegal, ALU_Control, 1'b0}, 64'd0);
    check_eq({tag, "_imm"}, 64'(imm32), 64'd0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  op;
    case ($urandom_range(0, 9))
      0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h23; 4: op = 7'h63;
      5: op = 7'h6f; 6: op = 7'h67; 7: op = 7'h17; 8: op = 7'h37;
      default: op = 7'h7f;
    endcase
    w = $urandom;
    w[6:0]   = op;
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; instruction = 32'd0; PC = '0;
    flush = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < SBD; k++) sbq.push_back(0);

    // Reset state
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    check_reset_outputs("reset");

    // addi x1,x0,5
    cycle(1'b1, 32'h00500093, 1'b0, 1'b1, 1'b0);
    check_eq("addi_valid", 64'(out_valid), 64'd1);
    check_eq("addi_rd", 64'(write_sel), 64'd1);
    check_eq("addi_imm", 64'(imm32), 64'h5);
    check_eq("addi_opb", 64'(op_B_sel), 64'd1);
    check_eq("addi_alu", 64'(ALU_Control), 64'd0);

    // add x2,x1,x1 stalls SB_DEPTH+1 cycles
    stalls = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 32'h00108133, 1'b0, 1'b1, 1'b0);
      if (seen_ready) break;
      stalls++;
    end
    check_eq("raw_stalls", 64'(stalls), 64'(SBD + 1));
    check_eq("add_srcs", 64'({out_valid, read_sel1, read_sel2}), 64'({1'b1, 5'd1, 5'd1}));

    // Drain, then beq and lui immediates
    for (int k = 0; k < SBD + 2; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'hFE208CE3, 1'b0, 1'b1, 1'b0);
    check_eq("beq_imm", 64'(imm32), 64'hFFFFFFF8);
    check_eq("beq_ctrl", 64'({out_valid, branch_op, ALU_Control}), 64'({1'b1, 1'b1, 6'b010000}));
    cycle(1'b1, 32'h123452B7, 1'b0, 1'b1, 1'b0);
    check_eq("lui_imm", 64'(imm32), 64'h12345000);

    // Flush while holding addi x3 with out_ready = 0
    cycle(1'b1, 32'h00300193, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    check_eq("hold_valid", 64'(out_valid), 64'd1);
    cycle(1'b1, 32'h00318333, 1'b1, 1'b0, 1'b0);
    check_eq("flush_in_ready", 64'(seen_ready), 64'd0);
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    cycle(1'b1, 32'h00318333, 1'b0, 1'b1, 1'b0);
    check_eq("flush_no_sb_x3", 64'(seen_ready), 64'd1);

    // Illegal opcode and rd = x0 producers
    for (int k = 0; k < SBD + 2; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0);
    check_eq("illegal", 64'({out_valid, illegal, wEn, mem_wEn}), 64'({1'b1, 1'b1, 1'b0, 1'b0}));
    cycle(1'b1, 32'h00100013, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h00000033, 1'b0, 1'b1, 1'b0);
    check_eq("x0_no_stall", 64'(seen_ready), 64'd1);

    // Reset during a stall
    for (int k = 0; k < SBD + 2; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h00500093, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h00108133, 1'b0, 1'b1, 1'b0);
    check_eq("stall_pre_rst", 64'(seen_ready), 64'd0);
    cycle(1'b1, 32'h00108133, 1'b0, 1'b1, 1'b1);
    check_reset_outputs("rst_stall");
    cycle(1'b1, 32'h00108133, 1'b0, 1'b1, 1'b0);
    check_eq("rst_in_ready", 64'(seen_ready), 64'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 9) < 8), rand_inst(), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
